// File: rtl/multicycle_alu_if.sv
// Handshake and operand bus for the multi-cycle ALU.
// The controller drives start/ctrl/operands; the ALU returns results and status.
interface multicycle_alu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, alu_ctrl, a, b,
    input  result, result_hi, zero, busy, done
  );

  modport slave (
    input  start, alu_ctrl, a, b,
    output result, result_hi, zero, busy, done
  );
endinterface

// File: rtl/multicycle_alu.sv
// ALU with single-cycle logic/arith ops and iterative shift-add mul
// and restoring div behind a start/busy/done handshake.
module multicycle_alu #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst,
  multicycle_alu_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opb;
  logic             is_div;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic             res_zero;
  logic             busy;
  logic             done;
  logic             multi;
  logic             last;

  logic [WIDTH-1:0] single_res;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  assign multi = (bus.alu_ctrl == 3'b101) ||
                 (bus.alu_ctrl == 3'b110);
  assign last  = (count == CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = multi ? CALC : DONE;
      CALC: if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Single-cycle operation result from live operands
  always_comb begin
    single_res = '0;
    unique case (bus.alu_ctrl)
      3'b000:  single_res = bus.a + bus.b;
      3'b001:  single_res = bus.a - bus.b;
      3'b010:  single_res = bus.a & bus.b;
      3'b011:  single_res = bus.a | bus.b;
      3'b100:  single_res = {{(WIDTH-1){1'b0}},
                             $signed(bus.a) < $signed(bus.b)};
      default: single_res = '0;
    endcase
  end

  // One mul (shift-add) or div (restoring) iteration
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, opb};
    if (is_div) begin
      nxt_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      nxt_lo = {lo[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], lo[WIDTH-1:1]};
    end
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      count    <= '0;
      res      <= '0;
      res_hi   <= '0;
      res_zero <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (multi) begin
              hi     <= '0;
              lo     <= bus.a;
              opb    <= bus.b;
              is_div <= (bus.alu_ctrl == 3'b110);
              count  <= CW'(WIDTH);
            end else begin
              res      <= single_res;
              res_hi   <= '0;
              res_zero <= (single_res == '0);
            end
          end
        end
        CALC: begin
          hi    <= nxt_hi;
          lo    <= nxt_lo;
          count <= count - CW'(1);
          if (last) begin
            res      <= nxt_lo;
            res_hi   <= nxt_hi;
            res_zero <= (nxt_lo == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result    = res;
  assign bus.result_hi = res_hi;
  assign bus.zero      = res_zero;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: driver pushes model results,
// monitor pops and compares on every done pulse.
module tb_multicycle_alu;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] h;
    int           lat;
    time          t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   run = 0;
  exp_t sb[$];

  multicycle_alu_if #(.WIDTH(W)) bus ();

  multicycle_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operation's definition
  function automatic exp_t model(input logic [2:0] c,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    longint unsigned p;
    int sx;
    int sy;
    e.r = '0;
    e.h = '0;
    e.lat = 1;
    e.t = 0;
    sx = (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
    sy = (y >= 16'h8000) ? int'(y) - 65536 : int'(y);
    case (c)
      3'd0: e.r = W'((int'(x) + int'(y)) % 65536);
      3'd1: e.r = W'((int'(x) - int'(y) + 65536) % 65536);
      3'd2: e.r = x & y;
      3'd3: e.r = x | y;
      3'd4: e.r = (sx < sy) ? 16'd1 : 16'd0;
      3'd5: begin
        p = longint'(x) * longint'(y);
        e.r = W'(p % 65536);
        e.h = W'(p / 65536);
        e.lat = W + 1;
      end
      3'd6: begin
        if (y == 0) begin
          e.r = 16'hFFFF;
          e.h = x;
        end else begin
          e.r = x / y;
          e.h = x % y;
        end
        e.lat = W + 1;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] c,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (bus.busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("issue_wait_idle", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b1;
    bus.alu_ctrl = c;
    bus.a = x;
    bus.b = y;
    @(posedge clk);
    if (push) begin
      e = model(c, x, y);
      e.t = $time;
      sb.push_back(e);
    end
    #1;
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.alu_ctrl = 3'($urandom);
  endtask

  // Monitor: compare every completed operation against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst || !bus.busy) run = 0;
    else run++;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", {16'd0, bus.result}, {16'd0, e.r});
        check("result_hi", {16'd0, bus.result_hi}, {16'd0, e.h});
        check("zero", {31'd0, bus.zero}, {31'd0, e.r == 0});
        check("latency", 32'($time - e.t), 32'((e.lat - 1) * 10 + 5));
        check("busy_cycles", 32'(run), 32'(e.lat));
      end
      run = 0;
    end
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.alu_ctrl = '0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", {16'd0, bus.result}, 32'd0);
    check("rst_hi", {16'd0, bus.result_hi}, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd1);

    // Reset in the middle of a mul after a nonzero result
    issue(3'd3, 16'h1234, 16'h00F0, 1'b1);
    issue(3'd5, 16'h1234, 16'h5678, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_result", {16'd0, bus.result}, 32'd0);
    check("midrst_hi", {16'd0, bus.result_hi}, 32'd0);
    check("midrst_zero", {31'd0, bus.zero}, 32'd1);

    // Directed corner cases
    issue(3'd0, 16'hFFFF, 16'h0001, 1'b1);
    issue(3'd1, 16'd5, 16'd7, 1'b1);
    issue(3'd4, 16'hFFFF, 16'h0001, 1'b1);
    issue(3'd4, 16'h0001, 16'hFFFF, 1'b1);
    issue(3'd5, 16'hFFFF, 16'hFFFF, 1'b1);
    issue(3'd6, 16'd100, 16'd7, 1'b1);
    issue(3'd6, 16'h1234, 16'h0000, 1'b1);
    issue(3'd7, 16'hABCD, 16'h1111, 1'b1);
    issue(3'd2, 16'hF0F0, 16'h3C3C, 1'b1);

    // Starts and operand changes while a div runs are ignored
    issue(3'd6, 16'hBEEF, 16'h0013, 1'b1);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (bus.done) break;
      bus.start = 1'b1;
      bus.alu_ctrl = 3'($urandom_range(0, 6));
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      n++;
    end
    bus.start = 1'b0;
    check("pulse_done_seen", {31'd0, bus.done}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [2:0] c;
      logic [W-1:0] x;
      logic [W-1:0] y;
      c = 3'($urandom_range(0, 7));
      x = W'($urandom);
      y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      issue(c, x, y, 1'b1);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("idle_after", {31'd0, bus.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
